spi_memory_responder: RTL



---
 rtl/spi_memory_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spi_memory_responder.sv
// Serves core load/store requests from a 23LC512-style SPI RAM (mode 0, 16-bit address).
// One SPI frame per access: opcode, address, then 1/2/4 data bytes, little-endian.
module spi_memory_responder #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_response,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    last_bit;
  logic [55:0]   tx_sr;
  logic [31:0]   rx_sr;
  logic [2:0]    opt_q;
  logic          is_read;

  logic          req;
  logic [7:0]    opcode;
  logic [55:0]   frame;
  logic [5:0]    frame_last;
  logic [31:0]   rd_value;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^address[31:16];
  assign req    = memory_read | memory_write;
  assign opcode = memory_write ? 8'h02 : 8'h03;
  // Store bytes are pre-ordered so the whole frame shifts out MSB-first from one register.
  assign frame  = {opcode, address[15:0], write_data[7:0], write_data[15:8],
                   write_data[23:16], write_data[31:24]};

  always_comb begin
    frame_last = 6'd55;
    if (option[1:0] == 2'b00)      frame_last = 6'd31;
    else if (option[1:0] == 2'b01) frame_last = 6'd39;
  end

  // First received byte lands highest in rx_sr; reverse bytes to right-align little-endian.
  always_comb begin
    rd_value = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
    case (opt_q[1:0])
      2'b00:   rd_value = {{24{~opt_q[2] & rx_sr[7]}}, rx_sr[7:0]};
      2'b01:   rd_value = {{16{~opt_q[2] & rx_sr[7]}}, rx_sr[7:0], rx_sr[15:8]};
      default: rd_value = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      last_bit        <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      opt_q           <= '0;
      is_read         <= 1'b0;
      read_data       <= '0;
      memory_response <= 1'b0;
      spi_cs_n        <= 1'b1;
      spi_sck         <= 1'b0;
      spi_mosi        <= 1'b0;
    end else begin
      memory_response <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state    <= SHIFT;
            spi_cs_n <= 1'b0;
            spi_mosi <= frame[55];
            tx_sr    <= {frame[54:0], 1'b0};
            is_read  <= ~memory_write;
            opt_q    <= option;
            last_bit <= frame_last;
            bit_cnt  <= '0;
            div_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx_sr   <= {rx_sr[30:0], spi_miso};
            end else if (bit_cnt == last_bit) begin
              state           <= DONE;
              spi_sck         <= 1'b0;
              spi_cs_n        <= 1'b1;
              spi_mosi        <= 1'b0;
              memory_response <= 1'b1;
              if (is_read) read_data <= rd_value;
            end else begin
              spi_sck  <= 1'b0;
              spi_mosi <= tx_sr[55];
              tx_sr    <= {tx_sr[54:0], 1'b0};
              bit_cnt  <= bit_cnt + 6'd1;
            end
          end
        end
        DONE: state <= GAP;
        GAP:  state <= IDLE;
      endcase
    end
  end

endmodule
